// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes an enumerated MIPS instruction request into its 32-bit
//            machine word and queues it in a small FIFO. The word at the
//            FIFO head is presented together with its instruction-memory
//            address, in program order.
// Revision : 1.0  initial release
// ============================================================================
module instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] BASE  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err,
  output logic [7:0]  illegal_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Instruction selector codes (op_sel[5] set means illegal)
  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_ADDI    = 5'd1;
  localparam logic [4:0] OP_SUB     = 5'd2;
  localparam logic [4:0] OP_AND     = 5'd3;
  localparam logic [4:0] OP_ANDI    = 5'd4;
  localparam logic [4:0] OP_OR      = 5'd5;
  localparam logic [4:0] OP_ORI     = 5'd6;
  localparam logic [4:0] OP_SLT     = 5'd7;
  localparam logic [4:0] OP_SLTU    = 5'd8;
  localparam logic [4:0] OP_MULT    = 5'd9;
  localparam logic [4:0] OP_MULTU   = 5'd10;
  localparam logic [4:0] OP_DIV     = 5'd11;
  localparam logic [4:0] OP_DIVU    = 5'd12;
  localparam logic [4:0] OP_MFHI    = 5'd13;
  localparam logic [4:0] OP_MFLO    = 5'd14;
  localparam logic [4:0] OP_MTHI    = 5'd15;
  localparam logic [4:0] OP_MTLO    = 5'd16;
  localparam logic [4:0] OP_LW      = 5'd17;
  localparam logic [4:0] OP_LH      = 5'd18;
  localparam logic [4:0] OP_LB      = 5'd19;
  localparam logic [4:0] OP_SW      = 5'd20;
  localparam logic [4:0] OP_SH      = 5'd21;
  localparam logic [4:0] OP_SB      = 5'd22;
  localparam logic [4:0] OP_BEQ     = 5'd23;
  localparam logic [4:0] OP_BNE     = 5'd24;
  localparam logic [4:0] OP_LUI     = 5'd25;
  localparam logic [4:0] OP_JAL     = 5'd26;
  localparam logic [4:0] OP_JR      = 5'd27;
  localparam logic [4:0] OP_ERET    = 5'd28;
  localparam logic [4:0] OP_SYSCALL = 5'd29;
  localparam logic [4:0] OP_MFC0    = 5'd30;
  localparam logic [4:0] OP_MTC0    = 5'd31;

  localparam logic [4:0] Z5 = 5'd0;

  function automatic logic [31:0] r_word(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] funct);
    return {6'h00, s, t, d, 5'b0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
    return {opc, s, t, im};
  endfunction

  logic [31:0]      enc_word;
  logic             legal;
  logic             accept;
  logic             push;
  logic             pop;

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [7:0]       ill_q, ill_d;

  // Combinational encoding of the incoming request into a machine word
  always_comb begin
    enc_word = 32'h0000_0000;
    unique case (op_sel[4:0])
      OP_ADD:     enc_word = r_word(rs, rt, rd, 6'h20);
      OP_SUB:     enc_word = r_word(rs, rt, rd, 6'h22);
      OP_AND:     enc_word = r_word(rs, rt, rd, 6'h24);
      OP_OR:      enc_word = r_word(rs, rt, rd, 6'h25);
      OP_SLT:     enc_word = r_word(rs, rt, rd, 6'h2A);
      OP_SLTU:    enc_word = r_word(rs, rt, rd, 6'h2B);
      OP_MULT:    enc_word = r_word(rs, rt, Z5, 6'h18);
      OP_MULTU:   enc_word = r_word(rs, rt, Z5, 6'h19);
      OP_DIV:     enc_word = r_word(rs, rt, Z5, 6'h1A);
      OP_DIVU:    enc_word = r_word(rs, rt, Z5, 6'h1B);
      OP_MFHI:    enc_word = r_word(Z5, Z5, rd, 6'h10);
      OP_MFLO:    enc_word = r_word(Z5, Z5, rd, 6'h12);
      OP_MTHI:    enc_word = r_word(rs, Z5, Z5, 6'h11);
      OP_MTLO:    enc_word = r_word(rs, Z5, Z5, 6'h13);
      OP_JR:      enc_word = r_word(rs, Z5, Z5, 6'h08);
      OP_SYSCALL: enc_word = r_word(Z5, Z5, Z5, 6'h0C);
      OP_ADDI:    enc_word = i_word(6'h08, rs, rt, imm);
      OP_ANDI:    enc_word = i_word(6'h0C, rs, rt, imm);
      OP_ORI:     enc_word = i_word(6'h0D, rs, rt, imm);
      OP_LW:      enc_word = i_word(6'h23, rs, rt, imm);
      OP_LH:      enc_word = i_word(6'h21, rs, rt, imm);
      OP_LB:      enc_word = i_word(6'h20, rs, rt, imm);
      OP_SW:      enc_word = i_word(6'h2B, rs, rt, imm);
      OP_SH:      enc_word = i_word(6'h29, rs, rt, imm);
      OP_SB:      enc_word = i_word(6'h28, rs, rt, imm);
      OP_BEQ:     enc_word = i_word(6'h04, rs, rt, imm);
      OP_BNE:     enc_word = i_word(6'h05, rs, rt, imm);
      OP_LUI:     enc_word = i_word(6'h0F, Z5, rt, imm);
      OP_JAL:     enc_word = {6'h03, target};
      OP_ERET:    enc_word = 32'h4200_0018;
      OP_MFC0:    enc_word = {6'h10, 5'h00, rt, rd, 11'b0};
      OP_MTC0:    enc_word = {6'h10, 5'h04, rt, rd, 11'b0};
      default:    enc_word = 32'h0000_0000;
    endcase
  end

  // Handshake decode; in_ready comes only from the registered count, so a
  // pop in the same cycle never frees a slot early
  always_comb begin
    legal     = ~op_sel[5];
    in_ready  = reset & (count_q < CNT_W'(DEPTH));
    out_valid = (count_q != '0);
    accept    = in_valid & in_ready;
    push      = accept & legal;
    pop       = out_valid & out_ready;
  end

  // Next-state computation for pointers, occupancy, address and error status
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    addr_d = pop ? addr_q + 32'd4 : addr_q;
    err_d  = err_q | (accept & ~legal);
    ill_d  = ill_q;
    if (accept && !legal && ill_q != 8'hFF) begin
      ill_d = ill_q + 8'd1;
    end
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE;
      err_q    <= 1'b0;
      ill_q    <= 8'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      ill_q    <= ill_d;
    end
  end

  // FIFO storage; contents need no reset because out_valid gates them
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= enc_word;
    end
  end

  // Output drive from registered state only
  always_comb begin
    out_word    = mem_q[rd_ptr_q];
    out_addr    = addr_q;
    err         = err_q;
    illegal_cnt = ill_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Self-checking bench for instr_encoder: a table-driven encoding
//            model plus a queue-based FIFO/address model compared against the
//            DUT every cycle, directed scenarios pinned with literal words,
//            and a randomized traffic phase.
// Revision : 1.0  initial release
// ============================================================================
module tb_instr_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  op_sel = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  illegal_cnt;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.DEPTH(DEPTH), .BASE(BASE)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op_sel(op_sel), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_addr(out_addr), .err(err), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  // Instruction tables: format kind (0 R, 1 I, 2 jal, 3 eret, 4 cop0),
  // funct/opcode/cop0-code, and forced-zero mask {rs, rt, rd}
  int KIND [32] = '{0,1,0,0,1,0,1,0,0, 0,0,0,0,0,0,0,0, 1,1,1,1,1,1,1,1,1, 2,0,3,0,4,4};
  int CODE [32] = '{'h20,'h08,'h22,'h24,'h0C,'h25,'h0D,'h2A,'h2B,'h18,'h19,'h1A,'h1B,
                    'h10,'h12,'h11,'h13,'h23,'h21,'h20,'h2B,'h29,'h28,'h04,'h05,'h0F,
                    'h03,'h08,0,'h0C,'h00,'h04};
  int ZMASK[32] = '{0,0,0,0,0,0,0,0,0,1,1,1,1,6,6,3,3,0,0,0,0,0,0,0,0,4,0,3,0,7,0,0};

  function automatic logic [31:0] model_enc(input int op, input logic [4:0] s_in,
      input logic [4:0] t_in, input logic [4:0] d_in, input logic [15:0] im,
      input logic [25:0] tg);
    logic [31:0] c;
    logic [31:0] z;
    logic [4:0]  s, t, d;
    c = CODE[op];
    z = ZMASK[op];
    s = z[2] ? 5'd0 : s_in;
    t = z[1] ? 5'd0 : t_in;
    d = z[0] ? 5'd0 : d_in;
    case (KIND[op])
      0:       return {6'h00, s, t, d, 5'h00, c[5:0]};
      1:       return {c[5:0], s, t, im};
      2:       return {6'h03, tg};
      3:       return 32'h4200_0018;
      default: return {6'h10, c[4:0], t_in, d_in, 11'h000};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference state and log of words actually popped from the DUT
  logic [31:0] m_q[$];
  logic [31:0] m_addr = BASE;
  logic        m_err  = 1'b0;
  int          m_ill  = 0;
  logic [31:0] log_w[$];
  logic [31:0] log_a[$];

  // Compare DUT against the model mid-cycle, then advance the model by the
  // handshakes that the coming rising edge will complete
  always @(negedge clk) begin
    logic exp_ready;
    logic exp_valid;
    exp_valid = (m_q.size() != 0);
    exp_ready = reset && (m_q.size() < DEPTH);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("out_addr", out_addr, m_addr);
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("illegal_cnt", {24'd0, illegal_cnt}, m_ill);
    if (exp_valid) chk("out_word", out_word, m_q[0]);
    if (!reset) begin
      m_q.delete();
      m_addr = BASE;
      m_err  = 1'b0;
      m_ill  = 0;
    end else begin
      if (exp_valid && out_ready) begin
        log_w.push_back(out_word);
        log_a.push_back(out_addr);
        void'(m_q.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (in_valid && exp_ready) begin
        if (op_sel < 6'd32) begin
          m_q.push_back(model_enc(int'(op_sel), rs, rt, rd, imm, target));
        end else begin
          m_err = 1'b1;
          if (m_ill < 255) m_ill++;
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge
  task automatic send(input int op, input int s, input int t, input int d,
                      input int im, input int tg);
    bit ok;
    ok       = 1'b0;
    op_sel   = 6'(op);
    rs       = 5'(s);
    rt       = 5'(t);
    rd       = 5'(d);
    imm      = 16'(im);
    target   = 26'(tg);
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: actual=not_accepted required=accepted op=%0d", op);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    cycles(n);
    reset = 1'b1;
    log_w.delete();
    log_a.delete();
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] w,
                         input logic [31:0] a);
    total++;
    if (log_w.size() <= idx) begin
      bad++;
      $display("FAIL %s: actual=missing required=%h@%h", name, w, a);
    end else begin
      total--;
      chk({name, "_word"}, log_w[idx], w);
      chk({name, "_addr"}, log_a[idx], a);
    end
  endtask

  initial begin
    #1;
    cycles(3);
    // Held reset: explicit reset-state pins
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_addr", out_addr, 32'h0000_3000);
    reset = 1'b1;

    // addi then add, consumer always ready
    do_reset(2);
    out_ready = 1'b1;
    send(1, 0, 1, 0, 5, 0);
    send(0, 1, 2, 3, 0, 0);
    cycles(4);
    chk_log("addi", 0, 32'h2001_0005, 32'h0000_3000);
    chk_log("add",  1, 32'h0022_1820, 32'h0000_3004);

    // lw, jal, eret, mtc0
    do_reset(2);
    send(17, 29, 4, 0, 8, 0);
    send(26, 0, 0, 0, 0, 'h0C03);
    send(28, 0, 0, 0, 0, 0);
    send(31, 0, 2, 12, 0, 0);
    cycles(4);
    chk_log("lw",   0, 32'h8FA4_0008, 32'h0000_3000);
    chk_log("jal",  1, 32'h0C00_0C03, 32'h0000_3004);
    chk_log("eret", 2, 32'h4200_0018, 32'h0000_3008);
    chk_log("mtc0", 3, 32'h4082_6000, 32'h0000_300C);

    // Back-pressure: fifth request held until the consumer drains
    do_reset(2);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(6, i, i + 1, 0, 'h100 + i, 0);
    fork
      send(6, 4, 5, 0, 'h104, 0);
      begin
        repeat (3) @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    cycles(8);
    for (int i = 0; i < 5; i++)
      chk_log("drain", i, {6'h0D, 5'(i), 5'(i + 1), 16'h100 + 16'(i)}, BASE + 32'(4 * i));

    // Illegal request between two legal ones
    do_reset(2);
    send(1, 0, 1, 0, 5, 0);
    send(40, 1, 1, 1, 1, 1);
    send(0, 1, 2, 3, 0, 0);
    cycles(4);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_cnt", {24'd0, illegal_cnt}, 32'd1);
    chk("ill_words", log_w.size(), 32'd2);
    chk_log("ill_first",  0, 32'h2001_0005, 32'h0000_3000);
    chk_log("ill_second", 1, 32'h0022_1820, 32'h0000_3004);

    // Reset mid-operation discards queued words and returns to BASE
    do_reset(2);
    out_ready = 1'b0;
    send(1, 0, 1, 0, 5, 0);
    send(50, 0, 0, 0, 0, 0);
    send(0, 1, 2, 3, 0, 0);
    do_reset(1);
    @(negedge clk);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_out_addr", out_addr, 32'h0000_3000);
    chk("mid_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(29, 0, 0, 0, 0, 0);
    cycles(3);
    chk_log("after_rst", 0, 32'h0000_000C, 32'h0000_3000);

    // Forced-zero fields
    do_reset(2);
    send(9, 3, 4, 7, 0, 0);
    send(25, 9, 5, 0, 'h1234, 0);
    cycles(3);
    chk_log("mult", 0, 32'h0064_0018, 32'h0000_3000);
    chk_log("lui",  1, 32'h3C05_1234, 32'h0000_3004);

    // illegal_cnt saturation
    do_reset(2);
    for (int i = 0; i < 260; i++) send(32 + (i % 32), 0, 0, 0, 0, 0);
    cycles(2);
    chk("sat_cnt", {24'd0, illegal_cnt}, 32'd255);

    // Randomized traffic including illegal selectors and occasional resets
    do_reset(2);
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      op_sel    = ($urandom_range(0, 9) == 0) ? 6'(32 + $urandom_range(0, 31))
                                              : 6'($urandom_range(0, 31));
      rs        = 5'($urandom);
      rt        = 5'($urandom);
      rd        = 5'($urandom);
      imm       = 16'($urandom);
      target    = 26'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      reset     = ($urandom_range(0, 199) != 0);
      cycles(1);
    end
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(10);
    chk("final_empty", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
